// File: rtl/uart_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_axil_pkg
// Description : Shared states, command/response codes and helpers for the
//               UART-to-AXI4-Lite bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_axil_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_ADDR = 4'd1,
        S_DATA = 4'd2,
        S_AW_W = 4'd3,
        S_B    = 4'd4,
        S_AR   = 4'd5,
        S_R    = 4'd6,
        S_SEND = 4'd7
    } state_e;

    localparam logic [3:0] ST_IDLE = S_IDLE;
    localparam logic [3:0] ST_ADDR = S_ADDR;
    localparam logic [3:0] ST_DATA = S_DATA;
    localparam logic [3:0] ST_AW_W = S_AW_W;
    localparam logic [3:0] ST_B    = S_B;
    localparam logic [3:0] ST_AR   = S_AR;
    localparam logic [3:0] ST_R    = S_R;
    localparam logic [3:0] ST_SEND = S_SEND;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;
    localparam logic [1:0] AXI_OKAY  = 2'b00;

    function automatic logic [7:0] resp_byte(input logic [1:0] resp);
        return (resp == AXI_OKAY) ? RSP_ACK : RSP_NAK;
    endfunction

endpackage : uart_axil_pkg
`default_nettype wire

// File: rtl/uart_axil_master_tx_seq.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_seq
// Description : Sends one byte through a level-handshake UART transmitter
//               (load, start while tx_done low, done once tx_done clears).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    input  logic       tx_done_i,
    output logic [7:0] tx_data_o,
    output logic       tx_start_o,
    output logic       idle_o,
    output logic       done_o
);

    localparam logic [1:0] SQ_IDLE = 2'd0;
    localparam logic [1:0] SQ_WAIT = 2'd1;
    localparam logic [1:0] SQ_ACT  = 2'd2;
    localparam logic [1:0] SQ_CLR  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        tx_data_d  = tx_data_q;
        tx_start_d = tx_start_q;
        done_o     = 1'b0;
        case (state_q)
            SQ_IDLE: begin
                if (load_i) begin
                    byte_d  = byte_i;
                    state_d = SQ_WAIT;
                end
            end
            SQ_WAIT: begin
                // A previous transfer may still be flagging completion.
                if (!tx_done_i) begin
                    tx_data_d  = byte_q;
                    tx_start_d = 1'b1;
                    state_d    = SQ_ACT;
                end
            end
            SQ_ACT: begin
                if (tx_done_i) begin
                    tx_start_d = 1'b0;
                    state_d    = SQ_CLR;
                end
            end
            default: begin
                if (!tx_done_i) begin
                    done_o  = 1'b1;
                    state_d = SQ_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SQ_IDLE;
            byte_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;
    assign idle_o     = (state_q == SQ_IDLE);

endmodule : uart_tx_seq
`default_nettype wire

// File: rtl/uart_axil_master.sv
`default_nettype none
// ============================================================================
// Module      : uart_axil_master
// Description : Byte-command UART front end driving an AXI4-Lite master.
//               Optional inter-byte timeout enabled by UART_AXIL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_axil_master
    import uart_axil_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    input  logic        tx_done_i,
    output logic [31:0] m_axil_awaddr_o,
    output logic        m_axil_awvalid_o,
    input  logic        m_axil_awready_i,
    output logic [31:0] m_axil_wdata_o,
    output logic [3:0]  m_axil_wstrb_o,
    output logic        m_axil_wvalid_o,
    input  logic        m_axil_wready_i,
    input  logic [1:0]  m_axil_bresp_i,
    input  logic        m_axil_bvalid_i,
    output logic        m_axil_bready_o,
    output logic [31:0] m_axil_araddr_o,
    output logic        m_axil_arvalid_o,
    input  logic        m_axil_arready_i,
    input  logic [31:0] m_axil_rdata_i,
    input  logic [1:0]  m_axil_rresp_i,
    input  logic        m_axil_rvalid_i,
    output logic        m_axil_rready_o,
    output logic        busy_o,
    output logic        cmd_err_o
);

    logic [3:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic [39:0] resp_q, resp_d;
    logic [2:0]  nleft_q, nleft_d;
    logic        err_q, err_d;

    logic        tmo_hit;
    logic        seq_load;
    logic        seq_idle;
    logic        seq_done;

`ifdef UART_AXIL_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;

    // Counts idle cycles between bytes of a partially received frame.
    always_comb begin
        tmo_d   = 32'd0;
        tmo_hit = 1'b0;
        if (((state_q == ST_ADDR) || (state_q == ST_DATA)) && !rx_valid_i) begin
            if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= 32'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        resp_d    = resp_q;
        nleft_d   = nleft_q;
        err_d     = 1'b0;

        // Bytes arriving while the bus or the UART is busy are discarded.
        if (rx_valid_i && (state_q != ST_IDLE) && (state_q != ST_ADDR) &&
            (state_q != ST_DATA)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i) begin
                    if ((rx_data_i == CMD_WRITE) || (rx_data_i == CMD_READ)) begin
                        is_wr_d = (rx_data_i == CMD_WRITE);
                        cnt_d   = 2'd0;
                        state_d = ST_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = ST_IDLE;
                end else if (rx_valid_i) begin
                    addr_d = {rx_data_i, addr_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = ST_DATA;
                        end else begin
                            arvalid_d = 1'b1;
                            state_d   = ST_AR;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = ST_IDLE;
                end else if (rx_valid_i) begin
                    data_d = {rx_data_i, data_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_AW_W;
                    end
                end
            end
            ST_AW_W: begin
                if (awvalid_q && m_axil_awready_i) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axil_wready_i) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                if (m_axil_bvalid_i) begin
                    resp_d  = {32'h0, resp_byte(m_axil_bresp_i)};
                    nleft_d = 3'd1;
                    state_d = ST_SEND;
                end
            end
            ST_AR: begin
                if (m_axil_arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (m_axil_rvalid_i) begin
                    resp_d  = {m_axil_rdata_i, resp_byte(m_axil_rresp_i)};
                    nleft_d = 3'd5;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (seq_done) begin
                    resp_d = {8'h00, resp_q[39:8]};
                    if (nleft_q == 3'd1) begin
                        nleft_d = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        nleft_d = nleft_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            is_wr_q   <= 1'b0;
            addr_q    <= 32'h0;
            data_q    <= 32'h0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            resp_q    <= 40'h0;
            nleft_q   <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            resp_q    <= resp_d;
            nleft_q   <= nleft_d;
            err_q     <= err_d;
        end
    end

    // The sequencer is reloaded with the next response byte once it idles.
    assign seq_load = (state_q == ST_SEND) && seq_idle;

    uart_tx_seq u_tx_seq (
        .clk        (clk),
        .rst        (rst),
        .load_i     (seq_load),
        .byte_i     (resp_q[7:0]),
        .tx_done_i  (tx_done_i),
        .tx_data_o  (tx_data_o),
        .tx_start_o (tx_start_o),
        .idle_o     (seq_idle),
        .done_o     (seq_done)
    );

    assign m_axil_awaddr_o  = addr_q;
    assign m_axil_awvalid_o = awvalid_q;
    assign m_axil_wdata_o   = data_q;
    assign m_axil_wstrb_o   = 4'hF;
    assign m_axil_wvalid_o  = wvalid_q;
    assign m_axil_bready_o  = (state_q == ST_B);
    assign m_axil_araddr_o  = addr_q;
    assign m_axil_arvalid_o = arvalid_q;
    assign m_axil_rready_o  = (state_q == ST_R);
    assign busy_o           = (state_q != ST_IDLE);
    assign cmd_err_o        = err_q;

endmodule : uart_axil_master
`default_nettype wire

// File: doc/uart_axil_master.md
UART_AXIL_MASTER -- requirements
Module: uart_axil_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100_000, is the inter-byte gap in clk cycles after which a partial command is discarded.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rx_data  in  8  received byte from UART core; valid when rx_valid=1.
REQ-005 rx_valid  in  1  one-cycle pulse per received byte (UART new_rx).
REQ-006 tx_data  out  8  byte to transmit; stable while tx_start=1.
REQ-007 tx_start  out  1  transmit request level (UART ena_tx).
REQ-008 tx_done  in  1  UART completion flag; may stay high for many cycles.
REQ-009 m_axil_aw*/w*/b*  AXI4-Lite master write channels: awaddr 32, awvalid, awready, wdata 32, wstrb 4, wvalid, wready, bresp 2, bvalid, bready.
REQ-010 m_axil_ar*/r*  AXI4-Lite master read channels: araddr 32, arvalid, arready, rdata 32, rresp 2, rvalid, rready.
REQ-011 busy  out  1  high from first address byte until final response byte completes.
REQ-012 cmd_err  out  1  one-cycle pulse on unknown command byte, timeout, or byte dropped while busy.

Function
REQ-013 Command frames: 0x57 'W' + 4 address bytes + 4 data bytes; 0x52 'R' + 4 address bytes; multi-byte fields LSB first.
REQ-014 States: IDLE, ADDR, DATA, AW_W, B, AR, R, SEND; IDLE->ADDR on valid command byte.
REQ-015 Unknown byte in IDLE: dropped, cmd_err pulse, remain IDLE.
REQ-016 ADDR->DATA (write) or ->AR (read) after 4th address byte; DATA->AW_W after 4th data byte.
REQ-017 AW_W: awvalid and wvalid asserted together next cycle, wstrb=4'hF; each deasserts independently on its own handshake; ->B when both done.
REQ-018 B: bready=1; on bvalid capture bresp, ->SEND with 1 byte: 0x06 if bresp==2'b00 else 0x15.
REQ-019 AR: arvalid until arready; R: rready=1; on rvalid ->SEND with 5 bytes: status (0x06/0x15 per rresp) then rdata LSB first.
REQ-020 SEND per byte: wait tx_done==0, drive tx_data, raise tx_start; drop tx_start the cycle after tx_done==1 is seen; next byte only after tx_done returns 0.
REQ-021 After last byte ->IDLE; busy falls same cycle.
REQ-022 rx_valid in AW_W/B/AR/R/SEND: byte dropped, cmd_err pulse, state unaffected.
REQ-023 AXI valids never deassert before handshake; addresses/data held stable while valid.
REQ-024 Byte counter 2-bit, wraps 3->0 on field completion.

Reset
REQ-025 rst=1: state IDLE, all valids/readies 0, tx_start 0, tx_data 0, busy 0, cmd_err 0, counters and timeout 0, address/data registers 0.
REQ-026 rst mid-transaction aborts immediately; no completion of pending AXI or UART handshake is attempted.

Configuration
REQ-027 Macro UART_AXIL_TIMEOUT_EN defined: in ADDR/DATA, counter reloads on each rx_valid; reaching TIMEOUT_CYCLES returns to IDLE with cmd_err pulse.
REQ-028 Macro undefined: no timeout counter; partial frames wait indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-029 Package uart_axil_pkg: state enum, CMD_WRITE=8'h57, CMD_READ=8'h52, RSP_ACK=8'h06, RSP_NAK=8'h15, AXI_OKAY=2'b00.
REQ-030 Sub-module uart_tx_seq implements REQ-020 handshake for one byte (load, start, done pulse).

Verification
REQ-031 Bytes 57 10 00 00 40 EF BE AD DE, bresp=0 -> awaddr=0x40000010, wdata=0xDEADBEEF, wstrb=F, tx byte 0x06.
REQ-032 Bytes 52 04 00 00 40, rdata=0x12345678 rresp=0 -> araddr=0x40000004, tx 06 78 56 34 12 in order.
REQ-033 Write with bresp=2'b10 -> tx 0x15 only; read rresp=2'b11 -> 15 + rdata bytes.
REQ-034 Byte 0xAA in IDLE -> cmd_err pulse, no AXI activity; byte during SEND -> cmd_err, response unchanged.
REQ-035 UART_AXIL_TIMEOUT_EN, TIMEOUT_CYCLES=50: 52 01 then 50 idle cycles -> cmd_err, IDLE; next 52 00 00 00 00 -> araddr=0.
REQ-036 awready delayed 5 cycles after wready -> wvalid drops at w handshake, awvalid held until awready, single B accepted.
